dr_link_tx: RTL

- Synchronous-to-dual-rail transmitter. Accepts a W-bit word on a valid/ready port in the clocked domain.
- Drives it onto a dual-rail, four-phase, return-to-zero link toward the asynchronous pipeline, for example a chain of MEM_CELL-style latches.
- Completes the handshake by synchronizing the receiver's acknowledge back into the clock domain.
- Sits at the clocked-to-async boundary, opposite the async-to-sync receiver.

---
 rtl/dr_link_tx_if.sv | 15 +
 rtl/dr_link_tx.sv | 119 +++++++++++
 2 files changed

// File: rtl/dr_link_tx_if.sv
// Upstream word port of the dual-rail transmitter.
//   in_valid : producer has a word
//   in_ready : transmitter accepts a word this cycle
//   in_data  : W-bit word
// master = producer side, slave = dr_link_tx side.
interface dr_link_tx_if #(
    parameter int W = 8
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;

    modport master (output in_valid, output in_data, input in_ready);
    modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/dr_link_tx.sv
// dr_link_tx: clocked valid/ready word -> dual-rail four-phase RTZ link.
//   clk, rst : clock, synchronous active-high reset
//   up       : dr_link_tx_if.slave (in_valid / in_ready / in_data)
//   ack_i    : async acknowledge from receiver (1 = codeword latched,
//              0 = spacer latched)
//   out      : 2*W rails, out[2i+1] = true rail, out[2i] = false rail of bit i
//   busy     : handshake in progress
//   err      : sticky watchdog error
// Optional macro DR_LINK_TX_TIMEOUT_EN builds the handshake watchdog;
// without it err is tied 0.
// SYNC_STAGES is intended for the range 2..4.
module dr_link_tx #(
    parameter int W           = 8,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 1024
) (
    input  logic             clk,
    input  logic             rst,
    dr_link_tx_if.slave      up,
    input  logic             ack_i,
    output logic [2*W-1:0]   out,
    output logic             busy,
    output logic             err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DATA = 2'd1,
        S_NULL = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [2*W-1:0]         out_q, out_d;
    logic                   busy_q;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   ack_s;
    logic [2*W-1:0]         code;

    // Per-bit dual-rail encoding: 1 -> rails 10, 0 -> rails 01.
    for (genvar i = 0; i < W; i++) begin : g_enc
        assign code[2*i+1] = up.in_data[i];
        assign code[2*i]   = ~up.in_data[i];
    end

    assign ack_s       = sync_q[SYNC_STAGES-1];
    // Synchronizer resets to 1, so nothing is accepted until the receiver
    // has been seen holding a spacer.
    assign up.in_ready = !rst && (state_q == S_IDLE) && !ack_s;
    assign out         = out_q;
    assign busy        = busy_q;

    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        case (state_q)
            S_IDLE: begin
                if (up.in_valid && up.in_ready) begin
                    // Whole codeword loads on one edge: no partial words.
                    out_d   = code;
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (ack_s) begin
                    out_d   = '0;
                    state_d = S_NULL;
                end
            end
            S_NULL: begin
                out_d = '0;
                if (!ack_s) state_d = S_IDLE;
            end
            default: begin
                out_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            out_q   <= '0;
            busy_q  <= 1'b0;
            sync_q  <= '1;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            busy_q  <= (state_d != S_IDLE);
            sync_q  <= {sync_q[SYNC_STAGES-2:0], ack_i};
        end
    end

`ifdef DR_LINK_TX_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] to_cnt;
    logic          err_q;

    // Counts cycles spent in the current DATA or NULL phase; restarts on
    // each phase entry and saturates. The FSM is never aborted.
    always_ff @(posedge clk) begin
        if (rst) begin
            to_cnt <= '0;
            err_q  <= 1'b0;
        end else if ((state_d != state_q) && (state_d != S_IDLE)) begin
            to_cnt <= '0;
        end else if ((state_q != S_IDLE) && (to_cnt != CW'(TIMEOUT))) begin
            to_cnt <= to_cnt + 1'b1;
            if (to_cnt == CW'(TIMEOUT - 1)) err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule
